// File: rtl/router_sync_n.sv
// Router write steering plus per-channel inactivity watchdog; sel registers in one cycle, steering/valid are combinational.
// No backpressure of its own: a full selected FIFO simply suppresses wr_en and is reported on fifo_full.
module router_sync_n #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] din,
    input  logic              detect_addr,
    input  logic              wr_en_reg,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] rd_en,
    output logic [ADDR_W-1:0] sel,
    output logic [NUM_CH-1:0] wr_en,
    output logic              fifo_full,
    output logic              addr_err,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic             addr_valid;
    logic [CNT_W-1:0] cnt [NUM_CH];

    assign addr_valid = (int'(sel) < NUM_CH);
    assign addr_err   = ~addr_valid;
    assign vld_out    = ~empty;

    // Decode by loop so an out-of-range sel never indexes past the full vector.
    always_comb begin
        wr_en     = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_valid && int'(sel) == i) begin
                fifo_full = full[i];
                wr_en[i]  = wr_en_reg & ~full[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel        <= '0;
            soft_reset <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (detect_addr) begin
                sel <= din;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                soft_reset[i] <= 1'b0;
                // Any read, empty cycle or pulse restarts the full window.
                if (soft_reset[i] || empty[i] || rd_en[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    soft_reset[i] <= 1'b1;
                    cnt[i]        <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_sync_n.sv
// Scoreboard bench for router_sync_n: a 3-channel/TIMEOUT=30 instance and an 8-channel/TIMEOUT=5 instance.
module tb_router_sync_n;

    typedef struct {
        int          cyc;
        logic [31:0] v;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t qa[$], qb[$], pa[$], pb[$];

    // instance A: NUM_CH=3, ADDR_W=2, TIMEOUT=30
    logic       rst_a, det_a, wer_a, ff_a, ae_a;
    logic [1:0] din_a, sel_a;
    logic [2:0] full_a, empty_a, rd_a, wr_a, vld_a, sr_a;

    router_sync_n #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(30)) dut_a (
        .clk(clk), .rst(rst_a), .din(din_a), .detect_addr(det_a), .wr_en_reg(wer_a),
        .full(full_a), .empty(empty_a), .rd_en(rd_a), .sel(sel_a), .wr_en(wr_a),
        .fifo_full(ff_a), .addr_err(ae_a), .vld_out(vld_a), .soft_reset(sr_a)
    );

    // instance B: NUM_CH=8, ADDR_W=3, TIMEOUT=5
    logic       rst_b, det_b, wer_b, ff_b, ae_b;
    logic [2:0] din_b, sel_b;
    logic [7:0] full_b, empty_b, rd_b, wr_b, vld_b, sr_b;

    router_sync_n #(.NUM_CH(8), .ADDR_W(3), .TIMEOUT(5)) dut_b (
        .clk(clk), .rst(rst_b), .din(din_b), .detect_addr(det_b), .wr_en_reg(wer_b),
        .full(full_b), .empty(empty_b), .rd_en(rd_b), .sel(sel_b), .wr_en(wr_b),
        .fifo_full(ff_b), .addr_err(ae_b), .vld_out(vld_b), .soft_reset(sr_b)
    );

    function automatic logic [31:0] pk(logic [7:0] s, logic [7:0] w, logic f, logic a, logic [7:0] vl);
        return {6'b0, s, w, f, a, vl};
    endfunction

    task automatic ea(logic [7:0] s, logic [7:0] w, logic f, logic a, logic [7:0] vl);
        qa.push_back('{cyc, pk(s, w, f, a, vl)});
    endtask

    task automatic eb(logic [7:0] s, logic [7:0] w, logic f, logic a, logic [7:0] vl);
        qb.push_back('{cyc, pk(s, w, f, a, vl)});
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(string nm, exp_t e, logic [31:0] act);
        n_cmp++;
        if (e.cyc != cyc || e.v !== act) begin
            n_bad++;
            $display("FAIL %s cycle %0d (expected cycle %0d): got %h, want %h", nm, cyc, e.cyc, act, e.v);
        end
    endtask

    task automatic chk_pulse(string nm, logic [7:0] sr, inout exp_t q[$]);
        exp_t p;
        if (sr != 8'h00) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL %s unexpected pulse cycle %0d: got %h, want none", nm, cyc, sr);
            end else begin
                p = q.pop_front();
                if (p.cyc != cyc || p.v[7:0] !== sr) begin
                    n_bad++;
                    $display("FAIL %s pulse: got %h at cycle %0d, want %h at cycle %0d", nm, sr, cyc, p.v[7:0], p.cyc);
                end
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            p = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s missing pulse: got 00 at cycle %0d, want %h", nm, cyc, p.v[7:0]);
        end
    endtask

    // monitor: pops expectations as the DUT presents outputs each cycle
    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].cyc <= cyc)
            chk_out("outs_a", qa.pop_front(), pk({6'b0, sel_a}, {5'b0, wr_a}, ff_a, ae_a, {5'b0, vld_a}));
        while (qb.size() > 0 && qb[0].cyc <= cyc)
            chk_out("outs_b", qb.pop_front(), pk({5'b0, sel_b}, wr_b, ff_b, ae_b, vld_b));
        chk_pulse("soft_reset_a", {5'b0, sr_a}, pa);
        chk_pulse("soft_reset_b", sr_b, pb);
    end

    initial begin
        int c;
        rst_a = 1; det_a = 0; wer_a = 0; din_a = 0; full_a = 0; empty_a = 3'b111; rd_a = 0;
        rst_b = 1; det_b = 0; wer_b = 0; din_b = 0; full_b = 0; empty_b = 8'hFF; rd_b = 0;
        repeat (2) @(posedge clk);
        #1;

        // ---- instance A: reset, latch, steering
        rst_a = 0;                              ea(0, 0, 0, 0, 0);
        nx(); det_a = 1; din_a = 2;             ea(0, 0, 0, 0, 0);
        nx(); det_a = 0; wer_a = 1;             ea(2, 8'h04, 0, 0, 0);
        nx(); det_a = 1; din_a = 1;             ea(2, 8'h04, 0, 0, 0);
        nx(); det_a = 0; full_a = 3'b010;       ea(1, 8'h00, 1, 0, 0);
        nx(); full_a = 3'b000;                  ea(1, 8'h02, 0, 0, 0);
        nx(); wer_a = 0; det_a = 1; din_a = 3;  ea(1, 8'h00, 0, 0, 0);
        nx(); det_a = 0; wer_a = 1; full_a = 3'b111; ea(3, 8'h00, 0, 1, 0);
        nx(); det_a = 1; din_a = 0;             ea(3, 8'h00, 0, 1, 0);
        nx(); det_a = 0; full_a = 3'b001;       ea(0, 8'h00, 1, 0, 0);
        nx(); full_a = 3'b000;                  ea(0, 8'h01, 0, 0, 0);
        nx(); wer_a = 0; empty_a = 3'b101; rd_a = 3'b010; ea(0, 0, 0, 0, 8'h02);
        nx(); empty_a = 3'b111; rd_a = 3'b111;  ea(0, 0, 0, 0, 0);
        nx(); rd_a = 3'b000;

        // ---- instance A: continuous idle pulses every TIMEOUT+1 cycles
        nx(); empty_a = 3'b110; c = cyc;        ea(0, 0, 0, 0, 8'h01);
        pa.push_back('{c + 30, 32'h1});
        pa.push_back('{c + 61, 32'h1});
        repeat (62) nx();
        empty_a = 3'b111;

        // ---- instance A: rd_en at terminal count restarts the window
        nx(); empty_a = 3'b110; c = cyc;
        pa.push_back('{c + 60, 32'h1});
        repeat (29) nx();
        rd_a = 3'b001;
        nx(); rd_a = 3'b000;
        repeat (31) nx();
        empty_a = 3'b111;

        // ---- instance A: one empty cycle mid-count restarts the window
        nx(); empty_a = 3'b110; c = cyc;
        pa.push_back('{c + 46, 32'h1});
        repeat (15) nx();
        empty_a = 3'b111;
        nx(); empty_a = 3'b110;
        repeat (31) nx();
        empty_a = 3'b111;

        // ---- instance A: rst overrides detect_addr
        nx(); det_a = 1; din_a = 1;             ea(0, 0, 0, 0, 0);
        nx(); rst_a = 1; din_a = 2;             ea(1, 0, 0, 0, 0);
        nx(); rst_a = 0; det_a = 0;             ea(0, 0, 0, 0, 0);

        // ---- instance B: steering sweep over all channels
        nx(); rst_b = 0;                        eb(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            nx(); det_b = 1; din_b = 3'(i); wer_b = 0; full_b = 8'h00;
            eb((i == 0) ? 8'd0 : 8'(i - 1), 0, 0, 0, 0);
            nx(); det_b = 0; wer_b = 1; full_b = ~(8'h01 << i);
            eb(8'(i), 8'h01 << i, 0, 0, 0);
        end
        nx(); full_b = 8'h80;                   eb(7, 8'h00, 1, 0, 0);

        // ---- instance B: three channels pulse together; rst during the pulse
        nx(); wer_b = 0; full_b = 8'h00; empty_b = 8'hDA; c = cyc;
        eb(7, 0, 0, 0, 8'h25);
        pb.push_back('{c + 5, 32'h25});
        pb.push_back('{c + 12, 32'h25});
        repeat (5) nx();
        rst_b = 1;
        nx();
        nx(); rst_b = 0;                        eb(0, 0, 0, 0, 8'h25);
        repeat (6) nx();
        empty_b = 8'hFF;

        repeat (3) nx();
        n_cmp++;
        if (pa.size() + pb.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_pulses: got %0d outstanding, want 0", pa.size() + pb.size());
        end
        n_cmp++;
        if (qa.size() + qb.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_outs: got %0d outstanding, want 0", qa.size() + qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/router_sync_n.md
# router_sync_n

Parametrised write-steering and inactivity-watchdog block for the N-port packet router. It latches the destination address at packet header, steers the FSM's write strobe to exactly one of NUM_CH output FIFOs, and reports the selected FIFO's full status. It also drives per-channel valid outputs and one-cycle soft-reset pulses when a channel's data sits unread for TIMEOUT cycles. It sits between the router FSM/register block and the NUM_CH output FIFOs.

## Interface
- NUM_CH, 3, number of output channels/FIFOs (2..16)
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= NUM_CH
- TIMEOUT, 30, consecutive unread cycles before soft reset (2..1023)
- clk  in  1  clock; all state updates on posedge clk
- rst  in  1  reset; synchronous, active-high
- din  in  ADDR_W  destination address (header bits)
- detect_addr  in  1  header strobe; latch din this cycle
- wr_en_reg  in  1  write request from FSM
- full  in  NUM_CH  per-FIFO full flags
- empty  in  NUM_CH  per-FIFO empty flags
- rd_en  in  NUM_CH  per-FIFO read enables from output ports
- sel  out  ADDR_W  latched destination address
- wr_en  out  NUM_CH  one-hot (or zero) FIFO write enables
- fifo_full  out  1  full flag of the selected FIFO
- addr_err  out  1  latched address is >= NUM_CH
- vld_out  out  NUM_CH  per-channel data-valid (FIFO not empty)
- soft_reset  out  NUM_CH  per-FIFO one-cycle soft-reset pulse

## Operation
- Address latch: sel <= din on clk when detect_addr=1; otherwise holds. addr_valid = (sel < NUM_CH).
- Steering (combinational from sel): wr_en[i] = wr_en_reg & addr_valid & (sel==i) & ~full[i]. Writes into a full FIFO are blocked here (new over previous generation).
- fifo_full = addr_valid ? full[sel] : 0. addr_err = ~addr_valid; when addr_err=1, wr_en=0 for all channels.
- vld_out[i] = ~empty[i], combinational.
- Watchdog per channel i, counter cnt_i of width clog2(TIMEOUT):
  - idle_i = ~empty[i] & ~rd_en[i].
  - If rst, soft_reset[i]=1, empty[i]=1, or rd_en[i]=1: cnt_i <= 0.
  - Else if idle_i and cnt_i == TIMEOUT-1: soft_reset[i] <= 1, cnt_i <= 0.
  - Else if idle_i: cnt_i <= cnt_i + 1.
  - soft_reset[i] <= 0 in every cycle not covered by the terminal-count rule, so the pulse lasts exactly one cycle.
- The counter clears when the FIFO becomes empty, unlike the previous generation, which froze it. Channels are fully independent.

## Timing
- Reset values (cycle after rst sampled high): sel=0, all cnt=0, soft_reset=0. Combinational outputs then follow: wr_en=0 unless wr_en_reg; addr_err=0 because sel=0 is valid when NUM_CH>=1.
- Address latency: one cycle. If detect_addr and wr_en_reg are high in the same cycle, wr_en uses the previous sel.
- wr_en, fifo_full, vld_out: zero-latency combinational outputs.
- Soft reset: if idle_i holds in cycles c..c+TIMEOUT-1, soft_reset[i]=1 in cycle c+TIMEOUT only.
- Counting resumes in the cycle after the pulse. A FIFO that stays non-empty and unread pulses every TIMEOUT+1 cycles.
- Counter recovery: any single rd_en[i] or empty[i] cycle during counting restarts the full TIMEOUT window.
- rd_en[i] while empty[i]: cnt_i=0, no pulse.
- rst mid-count or during a pulse: soft_reset cleared on the next edge with no extra pulse; rst overrides detect_addr.

## Test plan
- NUM_CH=3, TIMEOUT=30: rst 2 cycles -> sel=0, soft_reset=000; detect_addr with din=2, then wr_en_reg=1 -> wr_en=100 one cycle after latch.
- Write gating: sel=1, full=010, wr_en_reg=1 -> wr_en=000, fifo_full=1; full=000 -> wr_en=010, fifo_full=0.
- Invalid address: din=3 latched, NUM_CH=3 -> addr_err=1, wr_en=000, fifo_full=0 even with full=111.
- Timeout: empty[0]=0, rd_en[0]=0 from cycle 0 -> soft_reset[0]=1 only in cycle 30; with empty held low, next pulse in cycle 61.
- Recovery: idle 29 cycles, then rd_en[0]=1 one cycle, then idle again -> no pulse until 30 further idle cycles. Separately, empty[0]=1 for one cycle mid-count gives the same restart.
- Parameter sweep NUM_CH=8, ADDR_W=3, TIMEOUT=5: every channel steered correctly; three channels idle simultaneously pulse in the same cycle; rst asserted during a pulse -> pulse ends next cycle.
